mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 44 ++++
 rtl/mem_responder_lfsr.sv | 39 +++
 rtl/mem_responder.sv | 178 +++++++++++++++++
 tb/tb_mem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared definitions for the mem_responder slice:
//   - state_e       : responder FSM states (IDLE, WAIT, RESP)
//   - LFSR_SEED     : reset value of the stall-injection LFSR
//   - LFSR_TAPS     : Fibonacci tap mask for taps 16,14,13,11 (bits 15,13,12,10)
//   - LATENCY_MIN/MAX, DEPTH_MIN/MAX : legal parameter ranges
//   - merge_bytes() : byte-enable write merge helper
// -----------------------------------------------------------------------------
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  localparam int LATENCY_MIN = 32'sd1;
  localparam int LATENCY_MAX = 32'sd15;
  localparam int DEPTH_MIN   = 32'sd4;
  localparam int DEPTH_MAX   = 32'sd65536;

  // Replace each byte of old_word whose enable bit is set with the byte from new_word.
  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  byte_en
  );
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_responder_lfsr.sv
// -----------------------------------------------------------------------------
// mem_responder_lfsr
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that shifts left every cycle and
// reloads LFSR_SEED on reset. Used only for stall injection.
// Ports:
//   clk       in   clock
//   reset     in   asynchronous active-low reset
//   lfsr_next out  value the register takes on the next rising edge; the
//                  parent registers its stall decision from this so that the
//                  decision lines up with the LFSR value of the same cycle
// -----------------------------------------------------------------------------
module mem_responder_lfsr
  import mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] lfsr_next
);

  logic [15:0] lfsr_r;
  logic [15:0] lfsr_nxt_s;

  // Feedback is the XOR of the tapped bits, shifted in at the LSB.
  always_comb begin
    lfsr_nxt_s = {lfsr_r[14:0], ^(lfsr_r & LFSR_TAPS)};
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_nxt_s;
    end
  end

  assign lfsr_next = lfsr_nxt_s;

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Single-port word memory with a fixed-latency read response.
// Writes commit on the acceptance edge with byte enables and never respond.
// Reads sample the array on the acceptance edge (so a same-cycle write is not
// visible) and pulse resp_valid exactly LATENCY cycles later; dout holds the
// last response data until the next one.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words, power of two, 4..65536
//   LATENCY      acceptance-to-response cycles, 1..15
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   req_ready   out  request can be accepted this cycle
//   re          in   read request
//   we[3:0]     in   byte write enables
//   addr[31:0]  in   byte address; word index is addr[log2(DEPTH_WORDS)+1:2]
//   din[31:0]   in   write data
//   resp_valid  out  one-cycle read response pulse
//   dout[31:0]  out  read data
//
// Optional build macro: MEM_RESPONDER_STALL_INJECT_EN adds an LFSR that
// deasserts req_ready in IDLE/RESP whenever lfsr[1:0] == 2'b00.
// -----------------------------------------------------------------------------
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        req_ready,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic        resp_valid,
  output logic [31:0] dout
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  // Reject illegal configurations while elaborating.
  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("mem_responder: LATENCY %0d outside 1..15", LATENCY);
  end
  if (DEPTH_WORDS < DEPTH_MIN || DEPTH_WORDS > DEPTH_MAX ||
      (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("mem_responder: DEPTH_WORDS %0d not a power of two in 4..65536", DEPTH_WORDS);
  end

  state_e        state_r;
  state_e        state_nxt_s;
  logic [3:0]    cnt_r;
  logic [3:0]    cnt_nxt_s;
  logic          req_ready_r;
  logic          resp_valid_r;
  logic [31:0]   dout_r;
  logic [31:0]   dout_nxt_s;
  logic [31:0]   pend_r;
  logic [31:0]   mem_r [DEPTH_WORDS];
  logic [AW-1:0] idx_s;
  logic [31:0]   rd_word_s;
  logic          rd_accept_s;
  logic          wr_accept_s;
  logic          stall_nxt_s;
  logic          unused_addr_s;

  assign idx_s         = addr[AW+1:2];
  assign unused_addr_s = ^{addr[31:AW+2], addr[1:0]};
  assign rd_word_s     = mem_r[idx_s];
  assign rd_accept_s   = req_ready_r & re;
  assign wr_accept_s   = req_ready_r & (we != 4'b0000);

`ifdef MEM_RESPONDER_STALL_INJECT_EN
  logic [15:0] lfsr_nxt_s;

  mem_responder_lfsr u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .lfsr_next (lfsr_nxt_s)
  );

  // Stall is decided from the LFSR value that will be current next cycle.
  always_comb begin
    stall_nxt_s = (lfsr_nxt_s[1:0] == 2'b00);
  end
`else
  // No stall injection in this build.
  always_comb begin
    stall_nxt_s = 1'b0;
  end
`endif

  // Memory array: byte-enabled write on acceptance; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[idx_s] <= merge_bytes(mem_r[idx_s], din, we);
    end
  end

  // Next-state and latency counter; writes never change the state.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE, RESP: begin
        if (rd_accept_s) begin
          if (LATENCY == 1) begin
            state_nxt_s = RESP;
            cnt_nxt_s   = 4'd0;
          end else begin
            state_nxt_s = WAIT;
            cnt_nxt_s   = LAT_LOAD;
          end
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd1) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
        cnt_nxt_s = cnt_r - 4'd1;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // dout changes only on entry to RESP; with LATENCY 1 that is the acceptance edge itself.
  always_comb begin
    dout_nxt_s = dout_r;
    if (rd_accept_s && (LATENCY == 1)) begin
      dout_nxt_s = rd_word_s;
    end else if (state_r == WAIT && cnt_r == 4'd1) begin
      dout_nxt_s = pend_r;
    end else begin
      dout_nxt_s = dout_r;
    end
  end

  // Control and data registers; outputs are registered from next-state values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      dout_r       <= 32'h0000_0000;
      pend_r       <= 32'h0000_0000;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      req_ready_r  <= (state_nxt_s != WAIT) & ~stall_nxt_s;
      resp_valid_r <= (state_nxt_s == RESP);
      dout_r       <= dout_nxt_s;
      if (rd_accept_s) begin
        pend_r <= rd_word_s;
      end else begin
        pend_r <= pend_r;
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign dout       = dout_r;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Two responders: u_a (LATENCY 2) driven by a vector table, u_b (LATENCY 1)
// used for back-to-back reads. Hand sequences cover reset, write in RESP and
// reset during WAIT.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        a_req_ready, a_re, a_resp_valid;
  logic [3:0]  a_we;
  logic [31:0] a_addr, a_din, a_dout;
  logic        b_req_ready, b_re, b_resp_valid;
  logic [3:0]  b_we;
  logic [31:0] b_addr, b_din, b_dout;

  int checks = 0;
  int failures = 0;
  logic [31:0] a_hold = 32'h0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT_A)) u_a (
    .clk(clk), .reset(reset), .req_ready(a_req_ready), .re(a_re), .we(a_we),
    .addr(a_addr), .din(a_din), .resp_valid(a_resp_valid), .dout(a_dout)
  );

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT_B)) u_b (
    .clk(clk), .reset(reset), .req_ready(b_req_ready), .re(b_re), .we(b_we),
    .addr(b_addr), .din(b_din), .resp_valid(b_resp_valid), .dout(b_dout)
  );

`ifdef MEM_RESPONDER_STALL_INJECT_EN
  logic [15:0] lfsr_m;
  always @(posedge clk or negedge reset) begin
    if (!reset) lfsr_m <= 16'hACE1;
    else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end
`endif

  typedef struct {
    logic        re;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; waits (bounded) for a_req_ready, drives one request,
  // lets it be accepted, then returns at the following negedge with inputs idle.
  task automatic a_issue(input logic re, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] din);
    int n = 0;
    while (a_req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("a_ready_timeout", {31'b0, a_req_ready}, 32'h1);
    a_re = re; a_we = we; a_addr = addr; a_din = din;
    @(posedge clk);
    @(negedge clk);
    a_re = 1'b0; a_we = 4'h0; a_din = 32'h0;
  endtask

  task automatic b_write(input logic [31:0] addr, input logic [31:0] din);
    int n = 0;
    while (b_req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("b_ready_timeout", {31'b0, b_req_ready}, 32'h1);
    b_we = 4'hF; b_addr = addr; b_din = din;
    @(posedge clk);
    @(negedge clk);
    b_we = 4'h0;
    check("b_write_no_resp", {31'b0, b_resp_valid}, 32'h0);
  endtask

  // Apply one vector to u_a and check resp_valid/dout over LAT_A+1 cycles.
  task automatic a_run(input vec_t v, input int idx);
    logic is_rd;
    is_rd = v.re;
    a_issue(v.re, v.we, v.addr, v.din);
    for (int c = 1; c <= LAT_A + 1; c++) begin
      if (c > 1) @(negedge clk);
      check($sformatf("v%0d_resp_c%0d", idx, c), {31'b0, a_resp_valid},
            {31'b0, (is_rd && c == LAT_A)});
      if (is_rd && c == LAT_A) a_hold = v.exp;
      check($sformatf("v%0d_dout_c%0d", idx, c), a_dout, a_hold);
    end
  endtask

  initial begin
    a_re = 1'b0; a_we = 4'h0; a_addr = 32'h0; a_din = 32'h0;
    b_re = 1'b0; b_we = 4'h0; b_addr = 32'h0; b_din = 32'h0;

    vecs[0]  = '{1'b0, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 4'h2, 32'h0000_0010, 32'h0000_AA00, 32'h0};
    vecs[3]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_AAEF};
    vecs[4]  = '{1'b0, 4'hF, 32'h0000_0004, 32'h1234_5678, 32'h0};
    vecs[5]  = '{1'b1, 4'h0, 32'h0000_1004, 32'h0,         32'h1234_5678};
    vecs[6]  = '{1'b0, 4'hF, 32'h0000_0020, 32'h0000_0001, 32'h0};
    vecs[7]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h0000_0002, 32'h0000_0001};
    vecs[8]  = '{1'b1, 4'h0, 32'h0000_0020, 32'h0,         32'h0000_0002};
    vecs[9]  = '{1'b1, 4'h0, 32'h0000_0013, 32'h0,         32'hDEAD_AAEF};
    vecs[10] = '{1'b0, 4'h8, 32'h8000_0010, 32'h1100_0000, 32'h0};
    vecs[11] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'h11AD_AAEF};
    vecs[12] = '{1'b0, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0};
    vecs[13] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'h11AD_AAEF};

    // Reset values while reset is held and just after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_ready", {31'b0, a_req_ready}, 32'h1);
    check("rst_a_valid", {31'b0, a_resp_valid}, 32'h0);
    check("rst_a_dout", a_dout, 32'h0);
    check("rst_b_valid", {31'b0, b_resp_valid}, 32'h0);
    check("rst_b_dout", b_dout, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_a_valid", {31'b0, a_resp_valid}, 32'h0);
    check("post_rst_a_dout", a_dout, 32'h0);

    // Table-driven vectors on the LATENCY-2 instance.
    for (int i = 0; i < 14; i++) a_run(vecs[i], i);

    // Write accepted during RESP commits and produces no response.
    a_run('{1'b0, 4'hF, 32'h0000_0040, 32'hCAFE_F00D, 32'h0}, 20);
    a_issue(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    check("resp_seq_c1", {31'b0, a_resp_valid}, 32'h0);
    @(negedge clk);
    check("resp_seq_valid", {31'b0, a_resp_valid}, 32'h1);
    check("resp_seq_dout", a_dout, 32'hCAFE_F00D);
    check("resp_seq_ready", {31'b0, a_req_ready}, 32'h1);
    a_hold = 32'hCAFE_F00D;
    a_we = 4'hF; a_addr = 32'h0000_0044; a_din = 32'h0BAD_C0DE;
    @(posedge clk);
    @(negedge clk);
    a_we = 4'h0;
    check("resp_wr_no_resp", {31'b0, a_resp_valid}, 32'h0);
    check("resp_wr_dout_hold", a_dout, 32'hCAFE_F00D);
    a_run('{1'b1, 4'h0, 32'h0000_0044, 32'h0, 32'h0BAD_C0DE}, 21);

`ifndef MEM_RESPONDER_STALL_INJECT_EN
    // LATENCY 1: three back-to-back reads respond on consecutive cycles.
    b_write(32'h0000_0100, 32'hA5A5_0001);
    b_write(32'h0000_0104, 32'h5A5A_0002);
    b_write(32'h0000_0108, 32'h0F0F_0003);
    b_re = 1'b1; b_addr = 32'h0000_0100;
    @(posedge clk); @(negedge clk);
    check("b2b_valid0", {31'b0, b_resp_valid}, 32'h1);
    check("b2b_dout0", b_dout, 32'hA5A5_0001);
    b_addr = 32'h0000_0104;
    @(posedge clk); @(negedge clk);
    check("b2b_valid1", {31'b0, b_resp_valid}, 32'h1);
    check("b2b_dout1", b_dout, 32'h5A5A_0002);
    b_addr = 32'h0000_0108;
    @(posedge clk); @(negedge clk);
    check("b2b_valid2", {31'b0, b_resp_valid}, 32'h1);
    check("b2b_dout2", b_dout, 32'h0F0F_0003);
    b_re = 1'b0;
    @(posedge clk); @(negedge clk);
    check("b2b_end_valid", {31'b0, b_resp_valid}, 32'h0);
    check("b2b_end_hold", b_dout, 32'h0F0F_0003);
`endif

    // Reset asserted while a read waits: no response, clean restart.
    a_issue(1'b1, 4'h0, 32'h0000_0020, 32'h0);
    check("wait_ready_low", {31'b0, a_req_ready}, 32'h0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_valid", {31'b0, a_resp_valid}, 32'h0);
      check("abort_dout", a_dout, 32'h0);
    end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rel_valid", {31'b0, a_resp_valid}, 32'h0);
      check("rel_dout", a_dout, 32'h0);
`ifndef MEM_RESPONDER_STALL_INJECT_EN
      check("rel_ready", {31'b0, a_req_ready}, 32'h1);
`endif
    end

`ifdef MEM_RESPONDER_STALL_INJECT_EN
    // Idle req_ready follows the reference LFSR.
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("stall_ready", {31'b0, a_req_ready}, {31'b0, (lfsr_m[1:0] != 2'b00)});
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
